// File: rtl/elastic_fifo_pkg.sv
// Shared types, reset polarity and pointer sizing for the elastic FIFO.
// Optional transparent-when-empty mode is selected by ELASTIC_FIFO_BYPASS_EN.
package elastic_pkg;

    localparam logic RST_ACTIVE      = 1'b0;
    localparam int   CHAN_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CHAN_DATA_WIDTH-1:0] data;
        logic                       valid;
        logic                       ready;
    } channel_t;

    // Bits needed to hold values 0..depth-1, never less than one.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/elastic_fifo_if.sv
// Valid/ready input and output channels of the elastic FIFO.
// Unaffected by ELASTIC_FIFO_BYPASS_EN.
interface elastic_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/elastic_fifo_dataless.sv
// Pointer and occupancy control of the elastic FIFO, without the payload storage.
// With ELASTIC_FIFO_BYPASS_EN a token that passes straight through while empty is not written.
module elastic_fifo_dataless
    import elastic_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    localparam int PTR_W     = ptrWidth(NUM_SLOTS),
    localparam int CNT_W     = ptrWidth(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_insValid,
    input  logic             i_outsReady,
    output logic             o_insReady,
    output logic             o_empty,
    output logic             o_wrEn,
    output logic [PTR_W-1:0] o_wrAddr,
    output logic [PTR_W-1:0] o_rdAddr
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(NUM_SLOTS));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_outsReady & ~w_empty;

`ifdef ELASTIC_FIFO_BYPASS_EN
    assign w_push = i_insValid & ~w_full & ~(w_empty & i_outsReady);
`else
    assign w_push = i_insValid & ~w_full;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_insReady = ~w_full;
    assign o_empty    = w_empty;
    assign o_wrEn     = w_push;
    assign o_wrAddr   = r_tail;
    assign o_rdAddr   = r_head;

endmodule

// File: rtl/elastic_fifo.sv
// Elastic FIFO top: payload storage and output selection around the dataless controller.
// Defining ELASTIC_FIFO_BYPASS_EN makes the FIFO transparent while empty.
module elastic_fifo
    import elastic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic          clk,
    input  logic          rst,
    elastic_fifo_if.slave bus
);

    localparam int PTR_W = ptrWidth(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];

    logic             w_wrEn;
    logic             w_empty;
    logic             w_insReady;
    logic [PTR_W-1:0] w_wrAddr;
    logic [PTR_W-1:0] w_rdAddr;

    elastic_fifo_dataless #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_insValid  (bus.ins_valid),
        .i_outsReady (bus.outs_ready),
        .o_insReady  (w_insReady),
        .o_empty     (w_empty),
        .o_wrEn      (w_wrEn),
        .o_wrAddr    (w_wrAddr),
        .o_rdAddr    (w_rdAddr)
    );

    // Storage is cleared on reset so the idle output reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_mem[w_wrAddr] <= bus.ins;
        end
    end

    assign bus.ins_ready = w_insReady;

`ifdef ELASTIC_FIFO_BYPASS_EN
    assign bus.outs_valid = w_empty ? bus.ins_valid : 1'b1;
    assign bus.outs       = w_empty ? bus.ins : r_mem[w_rdAddr];
`else
    assign bus.outs_valid = ~w_empty;
    assign bus.outs       = r_mem[w_rdAddr];
`endif

endmodule

// File: tb/tb_elastic_fifo.sv
// Scoreboard bench for elastic_fifo (default build, ELASTIC_FIFO_BYPASS_EN undefined).
// Two instances: four slots and three slots, the latter exercising non-power-of-two wrap.
module tb_elastic_fifo;
    import elastic_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    elastic_fifo_if #(.DATA_WIDTH(DW)) busA ();
    elastic_fifo_if #(.DATA_WIDTH(DW)) busB ();

    elastic_fifo #(.DATA_WIDTH(DW), .NUM_SLOTS(4)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    elastic_fifo #(.DATA_WIDTH(DW), .NUM_SLOTS(3)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each FIFO is just an ordered list of held tokens.
    logic [DW-1:0] qA[$];
    logic [DW-1:0] qB[$];
    logic [DW-1:0] rxB[$];
    logic [DW-1:0] lastOutsB;
    logic expReadyA = 1'b1;
    logic expValidA = 1'b0;
    logic expReadyB = 1'b1;
    logic expValidB = 1'b0;
    logic accA = 1'b0;
    logic accB = 1'b0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitors compare DUT outputs against the model between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            expReadyA = (qA.size() != 4);
            expValidA = (qA.size() != 0);
            checkOutput("A.ins_ready", {31'b0, busA.ins_ready}, {31'b0, expReadyA});
            checkOutput("A.outs_valid", {31'b0, busA.outs_valid}, {31'b0, expValidA});
            if (expValidA) checkOutput("A.outs", busA.outs, qA[0]);
        end else begin
            expReadyA = 1'b1;
            expValidA = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            expReadyB = (qB.size() != 3);
            expValidB = (qB.size() != 0);
            lastOutsB = busB.outs;
            checkOutput("B.ins_ready", {31'b0, busB.ins_ready}, {31'b0, expReadyB});
            checkOutput("B.outs_valid", {31'b0, busB.outs_valid}, {31'b0, expValidB});
            if (expValidB) checkOutput("B.outs", busB.outs, qB[0]);
        end else begin
            expReadyB = 1'b1;
            expValidB = 1'b0;
        end
    end

    // Pop side of the scoreboard: head leaves when presented and accepted.
    always @(posedge clk) begin
        if (rst && expValidA && busA.outs_ready) void'(qA.pop_front());
        if (rst && expValidB && busB.outs_ready) begin
            rxB.push_back(lastOutsB);
            void'(qB.pop_front());
        end
    end

    // Issue side of the scoreboard: accepted tokens join the tail.
    always @(posedge clk) begin
        accA = rst && busA.ins_valid && expReadyA;
        accB = rst && busB.ins_valid && expReadyB;
        if (accA) qA.push_back(busA.ins);
        if (accB) qB.push_back(busB.ins);
    end

    task automatic applyStimulus(input int id, input logic [DW-1:0] data,
                                 input logic valid, input logic ready);
        if (id == 0) begin
            busA.ins        = data;
            busA.ins_valid  = valid;
            busA.outs_ready = ready;
        end else begin
            busB.ins        = data;
            busB.ins_valid  = valid;
            busB.outs_ready = ready;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Sends n tokens base.. holding each until accepted; readyMode 0=off 1=on 2=toggle 3=random.
    task automatic streamTokens(input int id, input int base, input int n,
                                input int readyMode, input int budget);
        int sent;
        logic rdy;
        sent = 0;
        for (int c = 0; c < budget; c++) begin
            case (readyMode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = (c % 2 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            applyStimulus(id, DW'(base + sent), sent < n, rdy);
            nextCycle();
            if ((id == 0 ? accA : accB) && sent < n) sent++;
        end
    endtask

    task automatic idle(input int id, input logic ready, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(id, '0, 1'b0, ready);
            nextCycle();
        end
    endtask

    initial begin
        applyStimulus(0, '0, 1'b0, 1'b0);
        applyStimulus(1, '0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #2;
        checkOutput("A.reset_outs_valid", {31'b0, busA.outs_valid}, '0);
        checkOutput("A.reset_ins_ready", {31'b0, busA.ins_ready}, 32'd1);
        checkOutput("A.reset_outs", busA.outs, '0);
        checkOutput("B.reset_outs", busB.outs, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        // Fill to full with the consumer stalled, then drain.
        streamTokens(0, 1, 5, 0, 8);
        streamTokens(0, 5, 1, 1, 4);
        idle(0, 1'b1, 6);

        // Wrap on the three-slot instance.
        rxB.delete();
        streamTokens(1, 0, 10, 2, 40);
        idle(1, 1'b1, 6);
        checkOutput("B.wrap_count", DW'(rxB.size()), DW'(10));
        for (int i = 0; i < 10 && i < rxB.size(); i++) begin
            checkOutput("B.wrap_order", rxB[i], DW'(i));
        end

        // Back-to-back streaming through an empty FIFO.
        streamTokens(0, 'h10, 8, 1, 8);
        idle(0, 1'b1, 3);

        // Push and pop offered together while full.
        streamTokens(0, 'h20, 4, 0, 6);
        streamTokens(0, 'h30, 2, 1, 6);
        idle(0, 1'b1, 6);

        // Asynchronous reset with three tokens held.
        streamTokens(0, 'h40, 3, 0, 3);
        applyStimulus(0, DW'('h77), 1'b1, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        qA.delete();
        qB.delete();
        #1;
        checkOutput("A.midreset_outs_valid", {31'b0, busA.outs_valid}, '0);
        checkOutput("A.midreset_ins_ready", {31'b0, busA.ins_ready}, 32'd1);
        checkOutput("A.midreset_outs", busA.outs, '0);
        applyStimulus(0, DW'('hA5), 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 applyStimulus(0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("A.after_reset_valid", {31'b0, busA.outs_valid}, 32'd1);
        checkOutput("A.after_reset_outs", busA.outs, DW'('hA5));
        idle(0, 1'b1, 3);

        // Randomized traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(0, DW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            applyStimulus(1, DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            nextCycle();
        end
        applyStimulus(0, '0, 1'b0, 1'b1);
        idle(1, 1'b1, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
